// File: rtl/opb_snapshot_bank_simulink2ppc_pkg.sv
// Shared constants and types for the OPB snapshot bank.
// Build option: SNAPSHOT_COUNTER_EN adds the SNAPCNT capture counter.
package opb_snapshot_bank_simulink2ppc_pkg;

    localparam int ARM_BIT  = 31;
    localparam int DONE_BIT = 30;
    localparam int AUTO_BIT = 29;

    localparam logic [29:0] CTRL_OFF = 30'd0;
    localparam logic [29:0] SNAP_OFF = 30'd1;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        HOLD
    } opb_state_e;

    // SNAPCNT sits directly after the last SNAP word
    function automatic logic [29:0] snapcnt_off(input int n_ch);
        return 30'(n_ch + 1);
    endfunction

endpackage

// File: rtl/opb_snapshot_bank_simulink2ppc_if.sv
// OPB slave bus bundle for the snapshot bank.
// Bit 0 is the MSB on every vector, as on the OPB.
interface opb_snapshot_bank_simulink2ppc_if;

    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus,
        output OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck,
        input  Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus,
        input  OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck,
        output Sl_retry, Sl_toutSup
    );

endinterface

// File: rtl/opb_snapshot_bank_simulink2ppc_opb_slave_fsm.sv
// OPB slave decode and single-beat ack FSM.
// Latches the beat, acks one cycle later, waits for select to drop.
module opb_slave_fsm
    import opb_snapshot_bank_simulink2ppc_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h01000900,
    parameter logic [31:0] C_HIGHADDR = 32'h010009FF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    opb_snapshot_bank_simulink2ppc_if.slave bus,
    output logic [29:0] reg_index_o,
    output logic        wr_strobe_o,
    output logic [0:31] wr_data_o,
    output logic [0:3]  wr_be_o,
    input  logic [0:31] rd_data_i
);

    logic [31:0] addr;
    logic [31:0] offset;
    logic        hit;
    logic [2:0]  unused_bits;

    opb_state_e  state_q;
    logic        ack_q;
    logic        rnw_q;
    logic [29:0] idx_q;
    logic [0:31] wdata_q;
    logic [0:3]  be_q;

    assign addr   = bus.OPB_ABus;
    assign offset = addr - C_BASEADDR;
    assign hit    = bus.OPB_select
                 && (addr >= C_BASEADDR)
                 && (addr <= C_HIGHADDR);

    assign unused_bits = {bus.OPB_seqAddr, offset[1:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            rnw_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hit) begin
                        state_q <= ACK;
                        ack_q   <= 1'b1;
                        rnw_q   <= bus.OPB_RNW;
                        idx_q   <= offset[31:2];
                        wdata_q <= bus.OPB_DBus;
                        be_q    <= bus.OPB_BE;
                    end
                end
                ACK: begin
                    state_q <= HOLD;
                    ack_q   <= 1'b0;
                end
                HOLD: begin
                    if (!bus.OPB_select) state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign reg_index_o = idx_q;
    assign wr_strobe_o = ack_q && !rnw_q;
    assign wr_data_o   = wdata_q;
    assign wr_be_o     = be_q;

    assign bus.Sl_xferAck = ack_q;
    assign bus.Sl_DBus    = (ack_q && rnw_q) ? rd_data_i : '0;
    assign bus.Sl_errAck  = 1'b0;
    assign bus.Sl_retry   = 1'b0;
    assign bus.Sl_toutSup = 1'b0;

endmodule

// File: rtl/opb_snapshot_bank_simulink2ppc.sv
// N_CH-word atomic snapshot bank served over OPB.
// Build option: SNAPSHOT_COUNTER_EN enables the SNAPCNT counter.
module opb_snapshot_bank_simulink2ppc
    import opb_snapshot_bank_simulink2ppc_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01000900,
    parameter logic [31:0] C_HIGHADDR   = 32'h010009FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex5",
    parameter int          N_CH         = 4
) (
    input  logic                 OPB_Clk,
    input  logic                 OPB_Rst,
    opb_snapshot_bank_simulink2ppc_if.slave opb,
    input  logic [N_CH*32-1:0]   user_data_in,
    input  logic                 user_valid,
    output logic                 snap_done
);

    localparam int    unused_aw     = C_OPB_AWIDTH;
    localparam int    unused_dw     = C_OPB_DWIDTH;
    localparam string unused_family = C_FAMILY;

    logic [29:0] reg_index;
    logic        wr_strobe;
    logic [0:31] wr_data;
    logic [0:3]  wr_be;
    logic [0:31] rd_data;
    logic [32:0] unused_wr;

    logic        arm_q, arm_d;
    logic        done_q, done_d;
    logic        auto_q, auto_d;
    logic [31:0] bank_q [N_CH];
    logic        capture;
    logic        ctrl_wr;

    opb_slave_fsm #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_fsm (
        .clk_i       (OPB_Clk),
        .rst_i       (OPB_Rst),
        .bus         (opb),
        .reg_index_o (reg_index),
        .wr_strobe_o (wr_strobe),
        .wr_data_o   (wr_data),
        .wr_be_o     (wr_be),
        .rd_data_i   (rd_data)
    );

    assign unused_wr = {wr_data[0:28], wr_data[DONE_BIT], wr_be[0:2]};

    assign capture = arm_q && user_valid;
    assign ctrl_wr = wr_strobe && (reg_index == CTRL_OFF) && wr_be[3];

    // capture resolves first; a same-edge arm write then wins
    always_comb begin
        arm_d  = arm_q;
        done_d = done_q;
        auto_d = auto_q;
        if (capture) begin
            done_d = 1'b1;
            if (!auto_q) arm_d = 1'b0;
        end
        if (ctrl_wr) begin
            auto_d = wr_data[AUTO_BIT];
            if (wr_data[ARM_BIT]) begin
                arm_d  = 1'b1;
                done_d = 1'b0;
            end
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            arm_q  <= 1'b0;
            done_q <= 1'b0;
            auto_q <= 1'b0;
            for (int n = 0; n < N_CH; n++) bank_q[n] <= '0;
        end else begin
            arm_q  <= arm_d;
            done_q <= done_d;
            auto_q <= auto_d;
            if (capture) begin
                for (int n = 0; n < N_CH; n++)
                    bank_q[n] <= user_data_in[n*32 +: 32];
            end
        end
    end

`ifdef SNAPSHOT_COUNTER_EN
    logic [31:0] cnt_q;

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst)      cnt_q <= '0;
        else if (capture) cnt_q <= cnt_q + 32'd1;
    end
`endif

    always_comb begin
        rd_data = '0;
        if (reg_index == CTRL_OFF) begin
            rd_data[ARM_BIT]  = arm_q;
            rd_data[DONE_BIT] = done_q;
            rd_data[AUTO_BIT] = auto_q;
        end
        for (int n = 0; n < N_CH; n++) begin
            if (reg_index == SNAP_OFF + 30'(n)) rd_data = bank_q[n];
        end
`ifdef SNAPSHOT_COUNTER_EN
        if (reg_index == snapcnt_off(N_CH)) rd_data = cnt_q;
`endif
    end

    assign snap_done = done_q;

endmodule

// File: tb/tb_opb_snapshot_bank_simulink2ppc.sv
// Scoreboard bench: driver pushes expected replies, monitor pops on ack.
// Reference model tracks arm/done/auto, bank and capture count per cycle.
module tb_opb_snapshot_bank_simulink2ppc;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h01000900;
    localparam logic [31:0] HIGH = 32'h010009FF;

    logic           clk;
    logic           rst;
    logic [N*32-1:0] ud;
    logic           uv;
    logic           snap_done;

    opb_snapshot_bank_simulink2ppc_if bus();

    opb_snapshot_bank_simulink2ppc dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (rst),
        .opb          (bus),
        .user_data_in (ud),
        .user_valid   (uv),
        .snap_done    (snap_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int acks   = 0;
    logic [31:0] expq[$];

    logic        m_arm, m_done, m_auto;
    logic [31:0] m_snap [N];
    logic [31:0] m_cnt;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_arm  = 0;
        m_done = 0;
        m_auto = 0;
        m_cnt  = 0;
        for (int n = 0; n < N; n++) m_snap[n] = 0;
    endtask

    // CTRL value: arm=0x1, done=0x2, auto=0x4; BE lane 3 is be[0]
    task automatic model_edge(input logic v,
                              input logic [N*32-1:0] d,
                              input logic wr,
                              input logic [31:0] wa,
                              input logic [31:0] wd,
                              input logic [3:0] be);
        if (m_arm && v) begin
            for (int n = 0; n < N; n++) m_snap[n] = d[n*32 +: 32];
            m_done = 1;
            m_cnt  = m_cnt + 1;
            if (!m_auto) m_arm = 0;
        end
        if (wr && wa == BASE && be[0]) begin
            m_auto = wd[2];
            if (wd[0]) begin
                m_arm  = 1;
                m_done = 0;
            end
        end
    endtask

    function automatic logic [31:0] exp_read(input int idx);
        if (idx == 0) return {29'd0, m_auto, m_done, m_arm};
        if (idx >= 1 && idx <= N) return m_snap[idx-1];
`ifdef SNAPSHOT_COUNTER_EN
        if (idx == N + 1) return m_cnt;
`endif
        return 32'd0;
    endfunction

    function automatic logic [N*32-1:0] rand_data();
        logic [N*32-1:0] d;
        for (int n = 0; n < N; n++) d[n*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic tick(input logic v,
                        input logic [N*32-1:0] d,
                        input logic wr,
                        input logic [31:0] wa,
                        input logic [31:0] wd,
                        input logic [3:0] be);
        uv = v;
        ud = d;
        @(posedge clk);
        model_edge(v, d, wr, wa, wd, be);
        @(negedge clk);
        chk("snap_done", {31'd0, snap_done}, {31'd0, m_done});
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, ud, 0, 0, 0, 0);
    endtask

    task automatic xfer(input logic [31:0] a,
                        input logic rnw,
                        input logic [31:0] wd,
                        input logic [3:0] be,
                        input logic v_ack,
                        input logic [N*32-1:0] d_ack);
        logic in_win;
        in_win = (a >= BASE) && (a <= HIGH);
        bus.OPB_ABus   = a;
        bus.OPB_RNW    = rnw;
        bus.OPB_DBus   = wd;
        bus.OPB_BE     = be;
        bus.OPB_select = 1;
        if (in_win) expq.push_back(rnw ? exp_read(int'((a - BASE) >> 2)) : 0);
        tick(0, ud, 0, 0, 0, 0);
        chk("ack_latency", {31'd0, bus.Sl_xferAck}, {31'd0, in_win});
        bus.OPB_select = 0;
        bus.OPB_DBus   = 0;
        tick(v_ack, d_ack, !rnw && in_win, a, wd, be);
        idle(2);
    endtask

    task automatic rd(input logic [31:0] a);
        xfer(a, 1, 0, 4'b0000, 0, ud);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd);
        xfer(a, 0, wd, 4'b1111, 0, ud);
    endtask

    task automatic rd_all();
        for (int i = 0; i <= N + 1; i++) rd(BASE + 32'(4*i));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.Sl_xferAck) begin
                acks++;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: data %h, no transfer pending",
                             bus.Sl_DBus);
                end else begin
                    chk("ack_data", bus.Sl_DBus, expq.pop_front());
                end
            end else begin
                chk("dbus_idle", bus.Sl_DBus, 32'd0);
            end
        end
    end

    initial begin
        int a0;
        logic [N*32-1:0] d;
        logic [N*32-1:0] d2;
        rst = 1;
        uv  = 0;
        ud  = 0;
        bus.OPB_ABus    = 0;
        bus.OPB_BE      = 0;
        bus.OPB_DBus    = 0;
        bus.OPB_RNW     = 0;
        bus.OPB_select  = 0;
        bus.OPB_seqAddr = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_dbus", bus.Sl_DBus, 0);
        chk("rst_ack", {31'd0, bus.Sl_xferAck}, 0);
        chk("rst_done", {31'd0, snap_done}, 0);
        chk("tied_zero", {29'd0, bus.Sl_errAck, bus.Sl_retry,
                          bus.Sl_toutSup}, 0);
        rst = 0;
        idle(2);

        rd(BASE);
        xfer(BASE, 0, 32'h1, 4'b0001, 0, ud);
        tick(1, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 0, 0, 0);
        rd_all();

        for (int i = 0; i < 4; i++) tick(1, rand_data(), 0, 0, 0, 0);
        rd_all();

        wr(BASE, 32'h5);
        for (int i = 0; i < 3; i++) begin
            tick(1, rand_data(), 0, 0, 0, 0);
            rd(BASE + 32'(4 * (i + 1)));
        end
        rd_all();
        wr(BASE, 32'h0);
        tick(1, rand_data(), 0, 0, 0, 0);
        rd(BASE);

        wr(BASE, 32'h1);
        d = rand_data();
        xfer(BASE, 0, 32'h1, 4'b0001, 1, d);
        rd_all();

        d2 = rand_data();
        xfer(BASE + 4, 1, 0, 4'b0000, 1, d2);
        rd(BASE + 4);
        rd(BASE);

        xfer(BASE, 0, 32'h1, 4'b1110, 0, ud);
        rd(BASE);

        a0 = acks;
        bus.OPB_ABus   = 32'h01000A00;
        bus.OPB_RNW    = 1;
        bus.OPB_select = 1;
        idle(16);
        bus.OPB_ABus   = BASE - 4;
        idle(4);
        bus.OPB_select = 0;
        idle(2);
        chk("out_of_window_noack", acks, a0);

        rd(32'h01000950);
        wr(32'h01000950, 32'hFFFF_FFFF);
        rd(BASE);

        wr(BASE, 32'h1);
        bus.OPB_ABus   = BASE;
        bus.OPB_RNW    = 1;
        bus.OPB_select = 1;
        rst = 1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        a0 = acks;
        rst = 0;
        bus.OPB_select = 0;
        idle(4);
        chk("reset_abort_noack", acks, a0);
        rd_all();

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: tick(1'($urandom), rand_data(), 0, 0, 0, 0);
                1: xfer(BASE, 0, $urandom & 32'h5, 4'($urandom),
                        1'($urandom), rand_data());
                2: xfer(BASE + 32'(4 * $urandom_range(0, 63)), 1, 0, 0,
                        1'($urandom), rand_data());
                default: xfer(BASE + 32'(4 * $urandom_range(1, 63)), 0,
                              $urandom, 4'($urandom), 1'($urandom),
                              rand_data());
            endcase
        end
        rd_all();

        idle(3);
        chk("queue_drained", 32'(expq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
